mux_sel_arbiter: RTL
====================

Name: mux_sel_arbiter

Overview:
- Round-robin select sequencer that sits directly upstream of the 4:1 mux (m41).
- Arbitrates four request lines and drives the mux select pair (s1, s0), so the data input D_i of the granted channel i = {s1,s0} appears at the mux Y output.
- Holds each grant for a bounded dwell time and inserts a dead cycle between grants, so a downstream consumer never samples a select change mid-transfer.

Parameters:
- NUM_CH, 4, number of request channels; fixed at 4 to match the 4:1 mux.
- SEL_W, 2, select width; equals log2(NUM_CH).
- HOLD_MAX, 8, maximum cycles a single grant stays asserted; legal range 1..15.
- CNT_W, 4, dwell counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk, input, 1, system clock; rising edge active.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 4, per-channel request; req[i] asks for mux input D_i.
- release_i, input, 1, consumer ends the current grant early.
- s0, output, 1, mux select LSB; connects to m41 S0.
- s1, output, 1, mux select MSB; connects to m41 S1.
- grant, output, 4, one-hot grant; all zero when no grant is active.
- busy, output, 1, high while in the GRANT state.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: state=IDLE, {s1,s0}=2'b00, grant=4'b0000, busy=0, rr_ptr=0, cnt=0. Assertion of rst_n mid-grant clears all of these immediately, with no clock edge needed.
- States are IDLE, GRANT, GAP.
- IDLE:
  - If req != 0 at the clock edge, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo 4.
  - Register {s1,s0}=index, grant=1<<index, busy=1, cnt=HOLD_MAX-1, and go to GRANT.
  - If req == 0, stay in IDLE with outputs unchanged.
- GRANT, end condition at a clock edge:
  - End occurs if release_i=1, or req[index]=0, or cnt==0.
  - On end: grant=0, busy=0, rr_ptr=(index+1) mod 4, go to GAP.
  - Otherwise cnt decrements by 1.
  - Simultaneous end causes produce a single end; there is no double advance of rr_ptr.
- GAP: lasts exactly one cycle, then IDLE unconditionally. Requests are ignored during GAP.
- Select hold: {s1,s0} keeps the last granted index through GAP and IDLE, and changes only on an IDLE->GRANT transition. The mux therefore sees no spurious select toggles.
- Latency: a request sampled at the IDLE edge gives grant visible one cycle later.
- Grant duration:
  - Without early release, grant is high for exactly HOLD_MAX cycles.
  - With HOLD_MAX=1, grant is high for 1 cycle.
- Inter-grant spacing: grant is low for a minimum of 2 cycles (GAP then IDLE).
- Wrap-around: rr_ptr advances 3 -> 0.
- Fairness: with all requests continuously asserted, grants cycle 0,1,2,3,0,...
- Invariants: grant is one-hot or zero; busy == |grant; when busy=1, {s1,s0} equals the index of the set grant bit.
- req changes during GRANT on non-granted channels have no effect until the next IDLE arbitration.

Decomposition:
- Package mux_arb_pkg holds:
  - enum arb_state_t {IDLE, GRANT, GAP};
  - localparams NUM_CH=4 and SEL_W=2.
- Sub-module rr_pick: purely combinational. Inputs req[3:0] and ptr[1:0]; outputs any and idx[1:0] (rotate, then priority-encode, then un-rotate).
- The FSM, dwell counter and output registers live in the top module.

Test Plan:
- Reset/idle: hold rst_n=0, set req=4'b1111, release rst_n -> s1,s0=00, grant=0000, busy=0 during reset; first grant=0001 one cycle after the first IDLE edge.
- Dwell timeout: HOLD_MAX=8, req=4'b0100 held -> grant=0100 for exactly 8 cycles, {s1,s0}=10 throughout and through GAP, then 2 low cycles, then regrant 0100.
- Round-robin wrap: req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001; rr_ptr wraps 3->0.
- Early end: grant on ch1, pulse release_i on the 3rd grant cycle -> grant drops after that edge (3 cycles high). Repeat with req[1] deasserted instead, with the same result; release_i and cnt==0 together -> single end, next grant goes to ch2.
- Async reset mid-grant: drop rst_n between clock edges during GRANT on ch3 -> grant=0000, {s1,s0}=00, busy=0 with no clock edge; after release, arbitration restarts at ch0.
- Integration with m41: drive D0..D3 = 0,1,0,1 and req=4'b1111 -> Y equals D_index on each busy cycle, and Y does not change during GAP/IDLE.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux select arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   NUM_CH      : number of request channels (matches the 4:1 mux)
//   SEL_W       : mux select width, log2(NUM_CH)
package mux_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request bit searching ptr, ptr+1, ... modulo NUM_CH.
//   req [NUM_CH-1:0] : request vector
//   ptr [SEL_W-1:0]  : highest-priority channel this round
//   any              : at least one request is set
//   idx [SEL_W-1:0]  : chosen channel (valid when any=1)
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              any,
    output logic [SEL_W-1:0]  idx
);

    // rot[j] holds the request of channel (j + ptr) mod NUM_CH, so bit 0 is
    // always the current highest-priority channel.
    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  off;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            logic [SEL_W-1:0] src;
            // Select-width addition wraps modulo NUM_CH on its own.
            assign src     = SEL_W'(gi) + ptr;
            assign rot[gi] = req[src];
        end
    endgenerate

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = SEL_W'(j);
            end
        end
    end

    // Un-rotate back to an absolute channel index.
    assign idx = off + ptr;
    assign any = |req;

endmodule : rr_pick

// File: rtl/mux_sel_arbiter.sv
// Round-robin select sequencer feeding a 4:1 mux (m41).
// Grants one request at a time, holds the grant for at most HOLD_MAX cycles,
// then inserts a GAP cycle and an IDLE cycle before the next grant. The mux
// select only moves on an IDLE->GRANT transition.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-channel request, req[i] asks for mux input D_i
//   release_i : consumer ends the current grant early
//   s0, s1    : mux select LSB / MSB
//   grant     : one-hot grant, zero when no grant is active
//   busy      : high while a grant is active
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              release_i,
    output logic              s0,
    output logic              s1,
    output logic [NUM_CH-1:0] grant,
    output logic              busy
);

    arb_state_t        state_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [NUM_CH-1:0] grant_reg;
    logic              busy_reg;
    logic [SEL_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              grant_end;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (rr_ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Any end cause collapses into one end event, so rr_ptr advances once.
    assign grant_end = release_i || !req[sel_reg] || (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            grant_reg  <= '0;
            busy_reg   <= 1'b0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        sel_reg   <= pick_idx;
                        grant_reg <= NUM_CH'(1) << pick_idx;
                        busy_reg  <= 1'b1;
                        // cnt counts the remaining cycles after the first one.
                        cnt_reg   <= CNT_W'(HOLD_MAX - 1);
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        grant_reg  <= '0;
                        busy_reg   <= 1'b0;
                        rr_ptr_reg <= sel_reg + SEL_W'(1);
                        state_reg  <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                GAP: begin
                    // Select stays on the last index; requests are ignored.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s0    = sel_reg[0];
    assign s1    = sel_reg[1];
    assign grant = grant_reg;
    assign busy  = busy_reg;

endmodule : mux_sel_arbiter
